// File: rtl/encrypt_core.sv
// encrypt_core: classify -> caesar shift -> rotating-key xor byte pipe.
// Inverse of decrypt_pipe under identical configuration.
module encrypt_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic [2:0] rot_freq,
  input  logic       shift_en,
  input  logic [3:0] shift_amt,
  input  logic       mode,
  output logic       v,
  output logic [7:0] dout
);

  logic       v1, up1, lo1;
  logic [7:0] d1;
  logic       v2;
  logic [7:0] d2;
  logic       v3;
  logic [7:0] d3;
  logic [1:0] idx;
  logic [2:0] cnt;

  logic [7:0] base, diff, shifted, key;
  logic [5:0] off, sum, wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      d1  <= 8'h00;
      up1 <= 1'b0;
      lo1 <= 1'b0;
    end else begin
      v1  <= en;
      d1  <= din;
      up1 <= (din >= 8'h41) && (din <= 8'h5A);
      lo1 <= (din >= 8'h61) && (din <= 8'h7A);
    end
  end

  always_comb begin
    base = up1 ? 8'h41 : 8'h61;
    diff = d1 - base;
    off  = diff[5:0];
    sum  = off + {2'b00, shift_amt};
    wrap = (sum >= 6'd26) ? sum - 6'd26 : sum;
    if (shift_en && (up1 || lo1))
      shifted = base + {2'b00, wrap};
    else
      shifted = d1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      d2 <= 8'h00;
      v3 <= 1'b0;
      d3 <= 8'h00;
    end else begin
      v2 <= v1;
      d2 <= shifted;
      v3 <= v2;
      d3 <= d2;
    end
  end

  always_comb begin
    key = k1;
    if (mode) begin
      unique case (idx)
        2'd1:    key = k2;
        2'd2:    key = k3;
        default: key = k1;
      endcase
    end
  end

  // Key schedule advances only on real bytes, so bubbles keep the stream aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
      cnt <= 3'd0;
    end else if (!mode) begin
      idx <= 2'd0;
      cnt <= 3'd0;
    end else if (v3) begin
      if (cnt == rot_freq) begin
        cnt <= 3'd0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v    <= 1'b0;
      dout <= 8'h00;
    end else begin
      v <= v3;
      if (v3)
        dout <= d3 ^ key;
    end
  end

endmodule

// File: tb/tb_encrypt_core.sv
// tb_encrypt_core: directed and random streams against an arithmetic
// cipher model, with an inverse-cipher round trip on every output byte.
module tb_encrypt_core;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] k1, k2, k3;
  logic [2:0] rot_freq;
  logic       shift_en;
  logic [3:0] shift_amt;
  logic       mode;
  logic       v;
  logic [7:0] dout;

  encrypt_core dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .k1(k1), .k2(k2), .k3(k3),
    .rot_freq(rot_freq), .shift_en(shift_en),
    .shift_amt(shift_amt), .mode(mode),
    .v(v), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int nbytes = 0;
  logic [7:0] last_exp = 8'h00;

  logic [7:0] exq[$];
  logic [7:0] orq[$];
  logic [7:0] kq[$];
  int         edq[$];

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] key_at(input int n);
    int r;
    if (!mode) return k1;
    r = (n / (int'(rot_freq) + 1)) % 3;
    if (r == 0) return k1;
    if (r == 1) return k2;
    return k3;
  endfunction

  function automatic logic [7:0] enc(input logic [7:0] b,
                                     input logic [7:0] key);
    int x;
    x = int'(b);
    if (shift_en) begin
      if (x >= 65 && x <= 90)
        x = (x - 65 + int'(shift_amt)) % 26 + 65;
      else if (x >= 97 && x <= 122)
        x = (x - 97 + int'(shift_amt)) % 26 + 97;
    end
    return 8'(x) ^ key;
  endfunction

  function automatic logic [7:0] dec(input logic [7:0] c,
                                     input logic [7:0] key);
    int x;
    x = int'(c ^ key);
    if (shift_en) begin
      if (x >= 65 && x <= 90)
        x = (x - 65 - int'(shift_amt) + 26) % 26 + 65;
      else if (x >= 97 && x <= 122)
        x = (x - 97 - int'(shift_amt) + 26) % 26 + 97;
    end
    return 8'(x);
  endfunction

  task automatic clear_q();
    exq.delete();
    orq.delete();
    kq.delete();
    edq.delete();
    last_exp = 8'h00;
    nbytes = 0;
  endtask

  // Drive at the current negedge; output due after the 4th posedge from here
  task automatic send_now(input logic [7:0] b, input logic [7:0] e);
    en = 1'b1;
    din = b;
    exq.push_back(e);
    orq.push_back(b);
    kq.push_back(key_at(nbytes));
    edq.push_back(edge_cnt + 4);
    nbytes++;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] e);
    @(negedge clk);
    send_now(b, e);
  endtask

  task automatic send_m(input logic [7:0] b);
    send(b, enc(b, key_at(nbytes)));
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic drain();
    int k;
    idle();
    k = 0;
    while (exq.size() != 0 && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk("drain", exq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    clear_q();
    @(negedge clk);
    chk("rst_v", v, 1'b0);
    chk("rst_dout", dout, 8'h00);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [7:0] e, o, k;
    int d;
    if (!rst) begin
      if (v) begin
        if (exq.size() == 0) begin
          chk("spurious_v", v, 1'b0);
        end else begin
          e = exq.pop_front();
          o = orq.pop_front();
          k = kq.pop_front();
          d = edq.pop_front();
          chk("dout", dout, e);
          chk("latency", edge_cnt, d);
          chk("roundtrip", dec(dout, k), o);
          last_exp = e;
        end
      end else begin
        chk("hold", dout, last_exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    din = 8'h00;
    k1 = 8'h00; k2 = 8'h00; k3 = 8'h00;
    rot_freq = 3'd0;
    shift_en = 1'b1;
    shift_amt = 4'd3;
    mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_v", v, 1'b0);
    chk("init_dout", dout, 8'h00);
    do_reset();

    send(8'h41, 8'h44);
    drain();
    send(8'h7A, 8'h63);
    drain();
    shift_amt = 4'd15;
    send(8'h5A, 8'h4F);
    drain();
    shift_amt = 4'd0;
    send(8'h61, 8'h61);
    drain();
    shift_amt = 4'd5;
    k1 = 8'hFF;
    send(8'h35, 8'hCA);
    drain();

    mode = 1'b1;
    rot_freq = 3'd1;
    k1 = 8'h01; k2 = 8'h02; k3 = 8'h04;
    shift_en = 1'b0;
    do_reset();
    send(8'h00, 8'h01); send(8'h00, 8'h01);
    send(8'h00, 8'h02); send(8'h00, 8'h02);
    send(8'h00, 8'h04); send(8'h00, 8'h04);
    send(8'h00, 8'h01);
    drain();

    do_reset();
    send(8'h00, 8'h01); idle();
    send(8'h00, 8'h01); idle();
    send(8'h00, 8'h02);
    drain();

    do_reset();
    send(8'h00, 8'h01);
    send(8'h00, 8'h01);
    send(8'h00, 8'h02);
    idle();
    @(posedge clk);
    #2;
    chk("pre_rst_v", v, 1'b1);
    clear_q();
    rst = 1'b1;
    #1;
    chk("async_v", v, 1'b0);
    chk("async_dout", dout, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    send_now(8'h00, 8'h01);
    drain();

    for (int s = 0; s < 4; s++) begin
      k1 = 8'($urandom); k2 = 8'($urandom); k3 = 8'($urandom);
      rot_freq = 3'($urandom);
      shift_en = 1'($urandom);
      shift_amt = 4'($urandom);
      mode = (s == 0) ? 1'b0 : 1'b1;
      if (s == 3) rot_freq = 3'd7;
      do_reset();
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(3, 0) == 0) idle();
        if ($urandom_range(1, 0) == 1)
          send_m(8'($urandom_range(122, 65)));
        else
          send_m(8'($urandom));
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
